// File: rtl/bp_pkg.sv
// Shared definitions for the gshare predictor and its branch resolve unit:
// control-transfer opcodes, resolve-unit state encoding and queue entry layout.
package bp_pkg;

    // Control-transfer opcodes (RV32 major opcode field)
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Address width carried by a queue entry; the resolve unit's ADDR_W
    // defaults to this so entries hold the full branch address.
    localparam int BP_ADDR_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RECOVER = 2'd2
    } bru_state_t;

    typedef struct packed {
        logic [BP_ADDR_W-1:0] addr;
        logic                 pred;
        logic                 is_jump;
    } bru_entry_t;

    // True for opcodes the predictor issues predictions for
    function automatic logic is_accepted_op(input logic [6:0] op);
        return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
    endfunction

    // Unconditional jumps always resolve taken
    function automatic logic is_jump_op(input logic [6:0] op);
        return (op == OP_JAL) || (op == OP_JALR);
    endfunction

endpackage

// File: rtl/bru_fifo.sv
// In-order circular buffer of outstanding predictions. Flush empties the
// queue and rewinds both pointers to slot 0; flush takes priority over
// push/pop. Push is ignored when full, pop is ignored when empty.
module bru_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  bru_entry_t       wr_data,
    input  logic             pop,
    input  logic             flush,
    output bru_entry_t       rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    bru_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_reg;
    // Head entry is needed in the same cycle as the pop decision
    assign rd_data = mem[rd_ptr_reg];

    // Entry storage: data only, no reset needed since count gates validity
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of two)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: queues predictions issued at fetch, matches them in
// order against execute outcomes, sends one training strobe per resolved
// branch and, on a mispredict, flushes younger entries and stalls the
// predictor for one recovery cycle.
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int ADDR_W = BP_ADDR_W,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pred_valid,
    input  logic [ADDR_W-1:0] pred_address,
    input  logic [6:0]        pred_opcode,
    input  logic              prediction,
    output logic              pred_ready,
    output logic              start,
    input  logic              res_valid,
    input  logic              res_taken,
    output logic              update,
    output logic [ADDR_W-1:0] update_address,
    output logic              branch_taken,
    output logic              mispredict,
    output logic [CNT_W-1:0]  count,
    output logic              err
);

    bru_state_t        state_reg;
    bru_state_t        state_next;
    bru_entry_t        wr_entry;
    bru_entry_t        head;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    logic              enq_attempt;
    logic              do_push;
    logic              do_pop;
    logic              effective_taken;
    logic              mis_now;
    logic              err_event;
    logic [CNT_W-1:0]  count_after;

    logic              update_reg;
    logic [ADDR_W-1:0] update_address_reg;
    logic              branch_taken_reg;
    logic              mispredict_reg;
    logic              err_reg;

    assign wr_entry.addr    = BP_ADDR_W'(pred_address);
    assign wr_entry.pred    = prediction;
    assign wr_entry.is_jump = is_jump_op(pred_opcode);

    bru_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (do_push),
        .wr_data (wr_entry),
        .pop     (do_pop),
        .flush   (mis_now),
        .rd_data (head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Queue control, mispredict detection, next state and handshake outputs
    always_comb begin
        pred_ready      = 1'b0;
        enq_attempt     = 1'b0;
        do_pop          = 1'b0;
        do_push         = 1'b0;
        effective_taken = 1'b0;
        mis_now         = 1'b0;
        err_event       = 1'b0;
        count_after     = fifo_count;
        state_next      = state_reg;

        pred_ready  = !fifo_full && (state_reg != RECOVER);
        // Predictions arriving during recovery belong to the squashed path
        enq_attempt = pred_valid && is_accepted_op(pred_opcode) && (state_reg != RECOVER);

        do_pop          = res_valid && !fifo_empty;
        effective_taken = head.is_jump | res_taken;
        mis_now         = do_pop && (effective_taken != head.pred);
        // A mispredict squashes the same-cycle enqueue along with the queue
        do_push         = enq_attempt && !fifo_full && !mis_now;

        err_event   = (res_valid && fifo_empty) || (enq_attempt && fifo_full);
        count_after = fifo_count + CNT_W'(do_push) - CNT_W'(do_pop);

        if (mis_now) begin
            state_next = RECOVER;
        end else if (state_reg == RECOVER) begin
            state_next = IDLE;
        end else if (count_after != '0) begin
            state_next = ACTIVE;
        end else begin
            state_next = IDLE;
        end
    end

    // Training strobe, mispredict pulse and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            update_reg         <= 1'b0;
            update_address_reg <= '0;
            branch_taken_reg   <= 1'b0;
            mispredict_reg     <= 1'b0;
            err_reg            <= 1'b0;
        end else begin
            update_reg     <= do_pop;
            mispredict_reg <= mis_now;
            if (do_pop) begin
                update_address_reg <= ADDR_W'(head.addr);
                branch_taken_reg   <= effective_taken;
            end
            if (err_event) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign start          = pred_ready;
    assign update         = update_reg;
    assign update_address = update_address_reg;
    assign branch_taken   = branch_taken_reg;
    assign mispredict     = mispredict_reg;
    assign count          = fifo_count;
    assign err            = err_reg;

endmodule
